// File: rtl/dca_matrix_lsu_row_unpacker_pkg.sv
// Shared txn_info layout for the matrix LSU load path: {is_signed, keep_row, alen, bitlen_m1, bitaddr}.
// Also used by the address generator that produces extraction entries.
package dca_matrix_lsu_row_unpacker_pkg;

  localparam int DEF_BW_MEMORY_ROW_BUFFER = 128;
  localparam int DEF_BW_BITADDR           = 7;
  localparam int DEF_BW_ALEN              = 8;

  function automatic int txn_info_width(input int bw_bitaddr, input int bw_alen);
    return 2 * bw_bitaddr + bw_alen + 2;
  endfunction

  function automatic int txn_keep_row_pos(input int bw_bitaddr, input int bw_alen);
    return 2 * bw_bitaddr + bw_alen;
  endfunction

  function automatic int txn_is_signed_pos(input int bw_bitaddr, input int bw_alen);
    return 2 * bw_bitaddr + bw_alen + 1;
  endfunction

  localparam int BW_TXN_INFO = 2 * DEF_BW_BITADDR + DEF_BW_ALEN + 2;

  typedef struct packed {
    logic                      is_signed;
    logic                      keep_row;
    logic [DEF_BW_ALEN-1:0]    alen;
    logic [DEF_BW_BITADDR-1:0] bitlen_m1;
    logic [DEF_BW_BITADDR-1:0] bitaddr;
  } txn_info_t;

endpackage

// File: rtl/dca_matrix_lsu_row_unpacker_field.sv
// Combinational bit-field extraction: logical shift, length mask, optional sign fill.
// Sign fill is built only with DCA_MATRIX_LSU_ROW_UNPACKER_SIGN_EXTEND_EN defined.
module dca_matrix_lsu_field_extract
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int W  = DEF_BW_MEMORY_ROW_BUFFER,
  parameter int BA = DEF_BW_BITADDR
) (
  input  logic [W-1:0]  row,
  input  logic [BA-1:0] bitaddr,
  input  logic [BA-1:0] bitlen_m1,
  input  logic          is_signed,
  output logic [W-1:0]  data,
  output logic [W-1:0]  mask
);

  logic [W:0]   mask_wide;
  logic [W-1:0] shifted;
  logic [W-1:0] field;
  logic         unused_mask_top;

  // W+1 bits so that bitlen_m1 = W-1 still produces an all-ones mask
  assign mask_wide       = ({{(W-1){1'b0}}, 2'b10} << bitlen_m1) - {{W{1'b0}}, 1'b1};
  assign mask            = mask_wide[W-1:0];
  assign unused_mask_top = mask_wide[W];
  assign shifted         = row >> bitaddr;
  assign field           = shifted & mask;

`ifdef DCA_MATRIX_LSU_ROW_UNPACKER_SIGN_EXTEND_EN
  assign data = (is_signed && shifted[bitlen_m1]) ? (field | ~mask) : field;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign data             = field;
`endif

endmodule

// File: rtl/dca_matrix_lsu_row_unpacker.sv
// Load-path row unpacker: buffers one aligned row, emits one masked field per txn entry.
// Optional sign fill: DCA_MATRIX_LSU_ROW_UNPACKER_SIGN_EXTEND_EN (in the field extractor).
module dca_matrix_lsu_row_unpacker
  import dca_matrix_lsu_row_unpacker_pkg::*;
#(
  parameter int BW_MEMORY_ROW_BUFFER = DEF_BW_MEMORY_ROW_BUFFER,
  parameter int BW_BITADDR           = DEF_BW_BITADDR,
  parameter int BW_ALEN              = DEF_BW_ALEN
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           rdata_valid,
  output logic                                           rdata_ready,
  input  logic [BW_MEMORY_ROW_BUFFER-1:0]                rdata,
  input  logic                                           rlast,
  input  logic                                           txn_valid,
  output logic                                           txn_ready,
  input  logic [txn_info_width(BW_BITADDR, BW_ALEN)-1:0] txn_info,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [BW_MEMORY_ROW_BUFFER-1:0]                out_data,
  output logic [BW_MEMORY_ROW_BUFFER-1:0]                out_mask,
  output logic                                           err_burst
);

  localparam int W        = BW_MEMORY_ROW_BUFFER;
  localparam int KEEP_POS = txn_keep_row_pos(BW_BITADDR, BW_ALEN);
  localparam int SIGN_POS = txn_is_signed_pos(BW_BITADDR, BW_ALEN);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]            state;
  logic                  row_full;
  logic [W-1:0]          row_buf;
  logic [BW_ALEN-1:0]    row_cnt;
  logic                  rlast_q;

  logic [BW_BITADDR-1:0] bitaddr;
  logic [BW_BITADDR-1:0] bitlen_m1;
  logic [BW_ALEN-1:0]    alen;
  logic                  keep_row;
  logic                  is_signed;

  logic                  row_fire;
  logic                  txn_fire;
  logic                  release_row;
  logic [W-1:0]          ext_data;
  logic [W-1:0]          ext_mask;

  assign bitaddr   = txn_info[BW_BITADDR-1:0];
  assign bitlen_m1 = txn_info[2*BW_BITADDR-1:BW_BITADDR];
  assign alen      = txn_info[2*BW_BITADDR+BW_ALEN-1:2*BW_BITADDR];
  assign keep_row  = txn_info[KEEP_POS];
  assign is_signed = txn_info[SIGN_POS];

  assign row_full    = (state == HOLD);
  assign txn_ready   = row_full & (~out_valid | out_ready);
  assign txn_fire    = txn_valid & txn_ready;
  assign release_row = txn_fire & ~keep_row;
  // Refill is allowed in the same cycle the held row is released
  assign rdata_ready = ~row_full | release_row;
  assign row_fire    = rdata_valid & rdata_ready;

  dca_matrix_lsu_field_extract #(
    .W  (W),
    .BA (BW_BITADDR)
  ) u_extract (
    .row       (row_buf),
    .bitaddr   (bitaddr),
    .bitlen_m1 (bitlen_m1),
    .is_signed (is_signed),
    .data      (ext_data),
    .mask      (ext_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      row_buf <= '0;
      rlast_q <= 1'b0;
    end else if (row_fire) begin
      state   <= HOLD;
      row_buf <= rdata;
      rlast_q <= rlast;
    end else if (release_row) begin
      state   <= EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
    end else if (txn_fire) begin
      out_valid <= 1'b1;
      out_data  <= ext_data;
      out_mask  <= ext_mask;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Burst length check: the row flagged rlast must be the one where row_cnt reaches alen
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      err_burst <= 1'b0;
    end else if (release_row) begin
      if ((row_cnt == alen) != rlast_q) err_burst <= 1'b1;
      row_cnt <= rlast_q ? '0 : row_cnt + 1'b1;
    end
  end

endmodule

// File: doc/dca_matrix_lsu_row_unpacker.md
Name: dca_matrix_lsu_row_unpacker

Overview:
- Load-path counterpart of the matrix LSU store-side row merger.
- Takes aligned memory rows from the AXI read-data path and holds each row in a buffer.
- Extracts one bit-field per transaction-info entry and emits it right-aligned with a bit mask to the matrix fill logic.
- One row may serve several entries (keep_row) before it is released.

Parameters:
- BW_MEMORY_ROW_BUFFER, 128, row width in bits; power of two, at least 32.
- BW_BITADDR, 7, log2(BW_MEMORY_ROW_BUFFER).
- BW_ALEN, 8, AXI burst length field width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high, one clock.
- rdata_valid  in  1  row valid.
- rdata_ready  out  1  row accepted.
- rdata  in  BW_MEMORY_ROW_BUFFER  aligned row.
- rlast  in  1  last row of burst.
- txn_valid  in  1  extraction entry valid.
- txn_ready  out  1  entry accepted.
- txn_info  in  2*BW_BITADDR+BW_ALEN+2  {is_signed, keep_row, alen, bitlen_m1, bitaddr}, bitaddr in LSBs.
- out_valid  out  1  extracted field valid.
- out_ready  in  1  consumer accepts.
- out_data  out  BW_MEMORY_ROW_BUFFER  field right-aligned to bit 0.
- out_mask  out  BW_MEMORY_ROW_BUFFER  ones in bits [bitlen_m1:0].
- err_burst  out  1  sticky rlast/alen mismatch.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_mask=0, err_burst=0. Internal row_full=0, row_buf=0, row_cnt=0, rlast_q=0. Reset mid-operation drops the buffered row and the pending output.
- State: EMPTY (row_full=0) and HOLD (row_full=1).
- Handshake signals:
  - row_fire = rdata_valid & rdata_ready.
  - txn_fire = txn_valid & txn_ready.
  - release = txn_fire & ~keep_row.
- Ready rules:
  - txn_ready = row_full & (~out_valid | out_ready).
  - rdata_ready = ~row_full | release. A new row may load in the same cycle the old row is released.
- Row load: on row_fire, row_buf<=rdata, rlast_q<=rlast, row_full<=1. If release occurs without row_fire, row_full<=0.
- Extraction, registered with 1-cycle latency from txn_fire:
  - out_data <= (row_buf >> bitaddr) & out_mask_next, logical shift.
  - out_mask_next = (2 << bitlen_m1) - 1, computed at BW_MEMORY_ROW_BUFFER+1 bits then truncated; bitlen_m1 = W-1 yields all ones.
  - Bits beyond the row top (bitaddr + bitlen_m1 >= W) read as 0. No wrap-around.
  - out_valid <= 1 on txn_fire. Otherwise out_valid clears on out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_mask hold stable.
- Burst check, on release:
  - If (row_cnt == alen) != rlast_q, err_burst <= 1 (sticky until rst).
  - row_cnt <= rlast_q ? 0 : row_cnt + 1, wrapping at BW_ALEN bits.
- Simultaneous events:
  - release + row_fire in one cycle: the new row is used only by txn entries from the next cycle on.
  - out_ready + txn_fire: out_valid stays 1 with the new data.
- No combinational path from txn_valid to out_valid.

Optional Feature:
- Macro: DCA_MATRIX_LSU_ROW_UNPACKER_SIGN_EXTEND_EN.
- Defined: when is_signed=1, out_data bits above bitlen_m1 are filled with extracted bit [bitlen_m1] instead of 0. out_mask is unchanged.
- Undefined: is_signed is ignored and upper bits are always zero.

Decomposition:
- Shared package: txn_info field widths and offsets (BW_TXN_INFO, bit positions of keep_row and is_signed), reused by the address generator that produces entries.
- Sub-module dca_matrix_lsu_field_extract, combinational: shift, mask, and optional sign extension.
- FSM, handshakes and burst check stay in the top module.

Test Plan:
- Single row 0x00..0F byte pattern, txn {bitaddr=8, bitlen_m1=15, keep_row=0} -> out_data=0x0201, out_mask=0xFFFF one cycle after txn_fire; rdata_ready high the same cycle.
- Same row, three txns bitaddr 0/32/64, bitlen_m1=31, keep_row=1,1,0 -> outputs 0x03020100, 0x07060504, 0x0B0A0908; rdata_ready low until the third txn fires.
- out_ready low for 4 cycles with txn_valid high -> txn_ready=0, out_data stable, no entry lost; the rest of the stream matches reference values.
- alen=3 burst with rlast on the 3rd row -> err_burst=1 on that release; a subsequent correct alen=1 burst leaves err_burst=1 until rst.
- Macro defined: field 0x8 at bitaddr=4, bitlen_m1=3, is_signed=1 -> out_data all ones above bit 3 (0x...FFF8). Undefined -> out_data=0x8.
- rst asserted while out_valid=1 and row held -> next cycle out_valid=0, rdata_ready=1, txn_ready=0.
